multi_alarm_clock: RTL and testbench



---
 rtl/multi_alarm_clock_pkg.sv | 27 ++
 rtl/multi_alarm_clock_if.sv | 12 +
 rtl/multi_alarm_clock_alarm_channel.sv | 99 +++++++++
 rtl/multi_alarm_clock.sv | 151 +++++++++++++++
 tb/tb_multi_alarm_clock.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/multi_alarm_clock_pkg.sv
// Shared types and helpers for the multi-alarm board clock.
package digital_clock_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } alarm_state_e;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_CLOCK  = 2'd1,
    MODE_EDIT   = 2'd2,
    MODE_STATUS = 2'd3
  } mode_e;

  typedef logic [7:0] bcd_hour_t;
  typedef logic [7:0] bcd_min_t;

  // Two-digit BCD increment that wraps to 00 after max.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    if (v == max) return 8'h00;
    if (v[3:0] == 4'h9) return {v[7:4] + 4'h1, 4'h0};
    return v + 8'h01;
  endfunction

endpackage

// File: rtl/multi_alarm_clock_if.sv
// Board-facing switch/button/display bundle of the multi-alarm clock.
interface multi_alarm_clock_if;
  logic [15:0] sw;
  logic [4:0]  btn;
  logic [31:0] seg_content;
  logic [7:0]  seg_dp;
  logic [7:0]  seg_en;
  logic [15:0] led;

  modport master (output sw, btn, input seg_content, seg_dp, seg_en, led);
  modport slave  (input sw, btn, output seg_content, seg_dp, seg_en, led);
endinterface

// File: rtl/multi_alarm_clock_alarm_channel.sv
// One alarm channel: alarm time, enable and the ring/snooze/timeout FSM.
module alarm_channel import digital_clock_pkg::*; #(
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_MINUTES = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sel,
  input  logic         inc_min,
  input  logic         inc_hour,
  input  logic         tog_en,
  input  logic         snooze,
  input  logic         dismiss,
  input  logic         tick,
  input  logic         min_pulse,
  input  bcd_hour_t    hh,
  input  bcd_min_t     mm,
  input  bcd_min_t     ss,
  output alarm_state_e state,
  output bcd_hour_t    ahh,
  output bcd_min_t     amm,
  output logic         en
);
  localparam int RW  = $clog2(RING_SECONDS + 1);
  localparam int SZW = $clog2(SNOOZE_MINUTES + 1);

  alarm_state_e   state_q, state_d;
  bcd_hour_t      ahh_q, ahh_d;
  bcd_min_t       amm_q, amm_d;
  logic           en_q, en_d;
  logic [RW-1:0]  ring_cnt_q, ring_cnt_d;
  logic [SZW-1:0] snz_cnt_q, snz_cnt_d;
  logic           edit, match;

  always_comb begin
    ahh_d      = ahh_q;
    amm_d      = amm_q;
    en_d       = en_q;
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
    snz_cnt_d  = snz_cnt_q;
    edit  = sel && (inc_min || inc_hour || (tog_en && en_q));
    match = en_q && (hh == ahh_q) && (mm == amm_q) && (ss == 8'h00) && tick;
    if (sel) begin
      if (inc_min)  amm_d = bcd_inc(amm_q, 8'h59);
      if (inc_hour) ahh_d = bcd_inc(ahh_q, 8'h23);
      if (tog_en)   en_d  = !en_q;
    end
    // Dismiss and edits of an active channel override every FSM transition.
    if (state_q != IDLE && (dismiss || edit)) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (match) begin
          state_d    = RING;
          ring_cnt_d = '0;
        end
        RING: if (snooze) begin
          state_d   = SNOOZE;
          snz_cnt_d = '0;
        end else if (tick) begin
          ring_cnt_d = ring_cnt_q + RW'(1);
          if (ring_cnt_d == RW'(RING_SECONDS)) state_d = IDLE;
        end
        SNOOZE: if (min_pulse) begin
          snz_cnt_d = snz_cnt_q + SZW'(1);
          if (snz_cnt_d == SZW'(SNOOZE_MINUTES)) begin
            state_d    = RING;
            ring_cnt_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ahh_q      <= '0;
      amm_q      <= '0;
      en_q       <= 1'b0;
      ring_cnt_q <= '0;
      snz_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      ahh_q      <= ahh_d;
      amm_q      <= amm_d;
      en_q       <= en_d;
      ring_cnt_q <= ring_cnt_d;
      snz_cnt_q  <= snz_cnt_d;
    end
  end

  assign state = state_q;
  assign ahh   = ahh_q;
  assign amm   = amm_q;
  assign en    = en_q;
endmodule

// File: rtl/multi_alarm_clock.sv
// BCD time-of-day clock with NUM_ALARMS alarm channels, seven-segment and LED drive.
module multi_alarm_clock import digital_clock_pkg::*; #(
  parameter int CLK_HZ         = 1000,
  parameter int NUM_ALARMS     = 4,
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_MINUTES = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] sw,
  input  logic [4:0]  btn,
  output logic [31:0] seg_content,
  output logic [7:0]  seg_dp,
  output logic [7:0]  seg_en,
  output logic [15:0] led
);
  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  logic [PW-1:0] presc_q, presc_d;
  bcd_hour_t     hh_q, hh_d;
  bcd_min_t      mm_q, mm_d, ss_q, ss_d;
  logic [4:0]    btn_q, btn_edge;
  logic [31:0]   seg_content_q, seg_content_d;
  logic [7:0]    seg_dp_q, seg_dp_d, seg_en_q, seg_en_d;
  logic [15:0]   led_q, led_d;
  mode_e         mode;
  logic [2:0]    k;
  logic          tick, adv, min_pulse, set_edge, hold;
  logic          unused_sw;

  alarm_state_e  ch_state [NUM_ALARMS];
  bcd_hour_t     ch_ahh   [NUM_ALARMS];
  bcd_min_t      ch_amm   [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] ch_en;

  assign mode      = mode_e'(sw[15:14]);
  assign k         = sw[2:0];
  assign btn_edge  = btn & ~btn_q;
  assign tick      = (presc_q == PW'(CLK_HZ - 1));
  assign unused_sw = ^sw[13:3];

  // A time-set edge coinciding with a tick consumes that tick; the prescaler still wraps.
  always_comb begin
    hold      = (mode == MODE_CLOCK) && sw[0];
    set_edge  = (mode == MODE_CLOCK) && (btn_edge[0] || btn_edge[1]);
    adv       = tick && !set_edge && !hold;
    min_pulse = adv && (ss_q == 8'h59);
    presc_d   = (tick || hold) ? '0 : presc_q + PW'(1);
    hh_d      = hh_q;
    mm_d      = mm_q;
    ss_d      = ss_q;
    if (set_edge) begin
      if (btn_edge[0]) mm_d = bcd_inc(mm_q, 8'h59);
      if (btn_edge[1]) hh_d = bcd_inc(hh_q, 8'h23);
    end else if (adv) begin
      ss_d = bcd_inc(ss_q, 8'h59);
      if (ss_q == 8'h59) begin
        mm_d = bcd_inc(mm_q, 8'h59);
        if (mm_q == 8'h59) hh_d = bcd_inc(hh_q, 8'h23);
      end
    end
    if (hold) ss_d = '0;
  end

  for (genvar g = 0; g < NUM_ALARMS; g++) begin : g_ch
    alarm_channel #(
      .RING_SECONDS  (RING_SECONDS),
      .SNOOZE_MINUTES(SNOOZE_MINUTES)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .sel      ((mode == MODE_EDIT) && (k == 3'(g))),
      .inc_min  (btn_edge[0]),
      .inc_hour (btn_edge[1]),
      .tog_en   (btn_edge[4]),
      .snooze   (btn_edge[2]),
      .dismiss  (btn_edge[3]),
      .tick     (adv),
      .min_pulse(min_pulse),
      .hh       (hh_q),
      .mm       (mm_q),
      .ss       (ss_q),
      .state    (ch_state[g]),
      .ahh      (ch_ahh[g]),
      .amm      (ch_amm[g]),
      .en       (ch_en[g])
    );
  end

  always_comb begin
    seg_content_d = '0;
    seg_dp_d      = '0;
    seg_en_d      = '0;
    led_d         = '0;
    for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
      led_d[i] = (ch_state[i] == RING);
      if (ch_state[i] != IDLE) led_d[15] = 1'b1;
    end
    case (mode)
      MODE_OFF: ;
      MODE_CLOCK: begin
        seg_content_d = {8'h00, hh_q, mm_q, ss_q};
        seg_en_d      = 8'h3F;
        seg_dp_d      = 8'h14;
      end
      MODE_EDIT: begin
        seg_content_d = {8'hEE, 24'h000000};
        seg_en_d      = 8'hFF;
        seg_dp_d      = 8'h10;
        for (int unsigned i = 0; i < NUM_ALARMS; i++)
          if (k == 3'(i))
            seg_content_d = {4'h0, 1'b0, k, ch_ahh[i], ch_amm[i], 4'h0, 3'b000, ch_en[i]};
      end
      MODE_STATUS: begin
        for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
          seg_content_d[4*i +: 4] = {2'b00, ch_state[i]};
          seg_en_d[i]             = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q       <= '0;
      hh_q          <= '0;
      mm_q          <= '0;
      ss_q          <= '0;
      btn_q         <= '0;
      seg_content_q <= '0;
      seg_dp_q      <= '0;
      seg_en_q      <= '0;
      led_q         <= '0;
    end else begin
      presc_q       <= presc_d;
      hh_q          <= hh_d;
      mm_q          <= mm_d;
      ss_q          <= ss_d;
      btn_q         <= btn;
      seg_content_q <= seg_content_d;
      seg_dp_q      <= seg_dp_d;
      seg_en_q      <= seg_en_d;
      led_q         <= led_d;
    end
  end

  assign seg_content = seg_content_q;
  assign seg_dp      = seg_dp_q;
  assign seg_en      = seg_en_q;
  assign led         = led_q;
endmodule

// File: tb/tb_multi_alarm_clock.sv
// Directed self-checking bench for multi_alarm_clock (CLK_HZ=10, 4 channels).
module tb_multi_alarm_clock;
  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cnt;

  multi_alarm_clock_if bus ();

  multi_alarm_clock #(
    .CLK_HZ        (10),
    .NUM_ALARMS    (4),
    .RING_SECONDS  (60),
    .SNOOZE_MINUTES(5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sw         (bus.sw),
    .btn        (bus.btn),
    .seg_content(bus.seg_content),
    .seg_dp     (bus.seg_dp),
    .seg_en     (bus.seg_en),
    .led        (bus.led)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [4:0] b);
    bus.btn = b;
    @(negedge clk);
    bus.btn = '0;
    @(negedge clk);
  endtask

  task automatic wait_led(input logic [15:0] mask, input int lim, output int c);
    c = 0;
    while ((bus.led & mask) == 16'h0000 && c < lim) begin
      @(negedge clk);
      c++;
    end
    chk("wait_led", {31'b0, |(bus.led & mask)}, 32'd1);
  endtask

  task automatic ring_len(input int b, output int d);
    d = 0;
    while (bus.led[b] && d < 800) begin
      @(negedge clk);
      d++;
    end
  endtask

  initial begin
    rst     = 1'b1;
    bus.sw  = '0;
    bus.btn = '0;
    cyc(3);
    chk("rst_led", {16'h0, bus.led}, 32'h0);
    chk("rst_content", bus.seg_content, 32'h0);
    chk("rst_en", {24'h0, bus.seg_en}, 32'h0);
    chk("rst_dp", {24'h0, bus.seg_dp}, 32'h0);

    // Seconds cadence: one SS step per 10 clocks.
    rst    = 1'b0;
    bus.sw = 16'h4000;
    cyc(10);
    chk("ss_c10", bus.seg_content, 32'h00000000);
    chk("clock_en", {24'h0, bus.seg_en}, 32'h3F);
    chk("clock_dp", {24'h0, bus.seg_dp}, 32'h14);
    cyc(1);
    chk("ss_c11", bus.seg_content, 32'h00000001);
    cyc(9);
    chk("ss_c20", bus.seg_content, 32'h00000001);
    cyc(1);
    chk("ss_c21", bus.seg_content, 32'h00000002);

    // Hold and set time to 23:59 with wrap checks.
    bus.sw = 16'h4001;
    for (int i = 0; i < 23; i++) press(5'b00010);
    chk("set_hh23", bus.seg_content, 32'h00230000);
    press(5'b00010);
    chk("hh_wrap", bus.seg_content, 32'h00000000);
    for (int i = 0; i < 23; i++) press(5'b00010);
    for (int i = 0; i < 59; i++) press(5'b00001);
    chk("set_mm59", bus.seg_content, 32'h00235900);
    press(5'b00001);
    chk("mm_wrap_nocarry", bus.seg_content, 32'h00230000);
    for (int i = 0; i < 59; i++) press(5'b00001);
    chk("hold_ss0", bus.seg_content, 32'h00235900);

    // Day rollover.
    bus.sw = 16'h4000;
    cyc(600);
    chk("pre_roll", bus.seg_content, 32'h00235959);
    cyc(1);
    chk("roll_000000", bus.seg_content, 32'h00000000);

    bus.sw = 16'h0000;
    cyc(2);
    chk("off_content", bus.seg_content, 32'h0);
    chk("off_en", {24'h0, bus.seg_en}, 32'h0);

    // Channel 1 alarm at 00:01.
    bus.sw = 16'h8001;
    cyc(1);
    press(5'b00001);
    press(5'b10000);
    chk("edit_ch1", bus.seg_content, 32'h01000101);
    chk("edit_en", {24'h0, bus.seg_en}, 32'hFF);
    chk("edit_dp", {24'h0, bus.seg_dp}, 32'h10);
    bus.sw = 16'hC000;
    cyc(2);
    chk("status_en", {24'h0, bus.seg_en}, 32'h0F);
    chk("status_idle", bus.seg_content, 32'h0);
    wait_led(16'h0002, 1500, cnt);
    chk("ring1_led", {16'h0, bus.led}, 32'h8002);
    chk("ring1_digit", bus.seg_content, 32'h00000010);
    ring_len(1, cnt);
    chk("ring1_len", cnt, 32'd600);
    chk("ring1_missed", {16'h0, bus.led}, 32'h0);

    // Snooze channel 1 (alarm moved to 00:03); re-ring after 5 minute rollovers.
    bus.sw = 16'h8001;
    cyc(1);
    press(5'b00001);
    press(5'b00001);
    chk("edit_ch1_03", bus.seg_content, 32'h01000301);
    bus.sw = 16'hC000;
    wait_led(16'h0002, 1500, cnt);
    press(5'b00100);
    chk("snz_led", {16'h0, bus.led}, 32'h8000);
    chk("snz_digit", bus.seg_content, 32'h00000020);
    wait_led(16'h0002, 4000, cnt);
    chk("snz_delay", cnt, 32'd2988);
    chk("rering_led", {16'h0, bus.led}, 32'h8002);
    ring_len(1, cnt);
    chk("rering_len", cnt, 32'd600);

    // Channels 0 and 2 at 00:10 ring together; snooze+dismiss dismisses.
    bus.sw = 16'h8000;
    cyc(1);
    for (int i = 0; i < 10; i++) press(5'b00001);
    press(5'b10000);
    bus.sw = 16'h8002;
    cyc(1);
    for (int i = 0; i < 10; i++) press(5'b00001);
    press(5'b10000);
    bus.sw = 16'hC000;
    wait_led(16'h0005, 1500, cnt);
    chk("dual_led", {16'h0, bus.led}, 32'h8005);
    chk("dual_digits", bus.seg_content, 32'h00000101);
    press(5'b01100);
    chk("dismiss_led", {16'h0, bus.led}, 32'h0);
    chk("dismiss_digits", bus.seg_content, 32'h0);

    // Out-of-range channel index.
    bus.sw = 16'h8006;
    cyc(2);
    chk("oor_display", bus.seg_content, 32'hEE000000);
    press(5'b00001);
    press(5'b00010);
    press(5'b10000);
    bus.sw = 16'h8000;
    cyc(2);
    chk("oor_ch0", bus.seg_content, 32'h00001001);
    bus.sw = 16'h8001;
    cyc(2);
    chk("oor_ch1", bus.seg_content, 32'h01000301);
    bus.sw = 16'h8002;
    cyc(2);
    chk("oor_ch2", bus.seg_content, 32'h02001001);
    bus.sw = 16'h8003;
    cyc(2);
    chk("oor_ch3", bus.seg_content, 32'h03000000);

    // Minute set landing on a tick cycle with MM=59.
    bus.sw = 16'h4001;
    cyc(2);
    for (int i = 0; i < 60 && bus.seg_content[15:8] != 8'h59; i++) press(5'b00001);
    chk("pre_set_tick", bus.seg_content, 32'h00005900);
    bus.sw = 16'h4000;
    cyc(9);
    bus.btn = 5'b00001;
    @(negedge clk);
    bus.btn = '0;
    @(negedge clk);
    chk("set_on_tick", bus.seg_content, 32'h00000000);
    cyc(10);
    chk("tick_after_set", bus.seg_content, 32'h00000001);

    // Asynchronous reset while channel 3 rings.
    bus.sw = 16'h8003;
    cyc(1);
    press(5'b00001);
    press(5'b10000);
    bus.sw = 16'hC000;
    wait_led(16'h0008, 1500, cnt);
    chk("ring3_led", {16'h0, bus.led}, 32'h8008);
    #1 rst = 1'b1;
    #1;
    chk("async_led", {16'h0, bus.led}, 32'h0);
    chk("async_content", bus.seg_content, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    cyc(2);
    chk("post_rst_en", {24'h0, bus.seg_en}, 32'h0F);
    chk("post_rst_led", {16'h0, bus.led}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
